// File: rtl/alu_mul_seq.sv
// Iterative 64-bit shift-and-add multiplier (low 64 product bits) that borrows the
// shared combinational datapath ALU, retiring one multiplier bit per clock.
module alu_mul_seq (
  input  logic        CLK,
  input  logic        resetl,
  input  logic        start,
  input  logic [63:0] multiplicand,
  input  logic [63:0] multiplier,
  output logic        busy,
  output logic        done,
  output logic [63:0] product,
  output logic        zero,
  output logic [63:0] aluBusA,
  output logic [63:0] aluBusB,
  output logic [3:0]  aluCtrl,
  input  logic [63:0] aluBusW,
  input  logic        aluZero
);

  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_PASSB = 4'b0111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    DONE = 2'd2
  } state_t;

  // Handshake: start is sampled only in IDLE; busy is high from the accepting
  // edge until the FSM returns to IDLE; done is a one-cycle pulse in DONE and
  // the product/zero pair is valid from then until the next accepted start.
  state_t      state;
  logic [63:0] acc;
  logic [63:0] mc;
  logic [63:0] mp;
  logic [63:0] mp_next;
  logic        zero_q;
  logic        busy_q;
  logic        done_q;

  assign mp_next = mp >> 1;

  always_ff @(posedge CLK) begin
    if (!resetl) begin
      state  <= IDLE;
      acc    <= 64'd0;
      mc     <= 64'd0;
      mp     <= 64'd0;
      zero_q <= 1'b1;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc    <= 64'd0;
            mc     <= multiplicand;
            mp     <= multiplier;
            busy_q <= 1'b1;
            state  <= STEP;
          end
        end
        STEP: begin
          acc    <= aluBusW;
          zero_q <= aluZero;
          mc     <= mc << 1;
          mp     <= mp_next;
          // Stop as soon as no set multiplier bits remain.
          if (mp_next == 64'd0) begin
            done_q <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  // ALU request: add the shifted multiplicand when the current bit is set,
  // otherwise pass the accumulator through unchanged.
  always_comb begin
    aluCtrl = ALU_PASSB;
    aluBusA = 64'd0;
    aluBusB = 64'd0;
    if (state == STEP) begin
      if (mp[0]) begin
        aluCtrl = ALU_ADD;
        aluBusA = acc;
        aluBusB = mc;
      end else begin
        aluCtrl = ALU_PASSB;
        aluBusA = 64'd0;
        aluBusB = acc;
      end
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = acc;
  assign zero    = zero_q;

endmodule
